// File: rtl/data_mem_sync.sv
// data_mem_sync: single-port synchronous word memory with a valid/ready request
// channel and a valid/ready response channel. After reset every word is cleared
// by a one-word-per-cycle sweep before requests are accepted. A stalled response
// is held stable; a request accepted on the same edge that enters the stall is
// parked in a one-entry slot and presented once the stalled response drains.
module data_mem_sync #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  init_done
);

  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t              state;
  logic [IW-1:0]       sweep_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                pend_valid;
  logic [DATA_W-1:0]   pend_rdata;
  logic                pend_err;

  logic                accept;
  logic                misaligned;
  logic                out_of_range;
  logic                req_err;
  logic                wr_en;
  logic [IW-1:0]       idx;
  logic [DATA_W-1:0]   rsp_data;

  // Decode the request: word index, error classification and response data.
  always_comb begin
    accept       = req_valid && req_ready;
    idx          = IW'(req_addr >> OFF);
    misaligned   = 1'b0;
    for (int b = 0; b < OFF; b++) begin
      misaligned = misaligned | req_addr[b];
    end
    out_of_range = |(req_addr >> (OFF + IW));
    req_err      = misaligned || out_of_range;
    wr_en        = accept && req_we && !req_err;
    if (req_we || req_err) begin
      rsp_data = '0;
    end else begin
      rsp_data = mem[idx];
    end
  end

  // Memory array: clear sweep in INIT, byte-enabled writes on accepted requests.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[sweep_cnt] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be[b]) begin
          mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      sweep_cnt  <= '0;
      req_ready  <= 1'b0;
      init_done  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      pend_valid <= 1'b0;
      pend_rdata <= '0;
      pend_err   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          sweep_cnt <= sweep_cnt + IW'(1);
          if (sweep_cnt == LAST_IDX) begin
            state     <= RUN;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          if (resp_valid && !resp_ready) begin
            // Response blocked: freeze it and park any request taken this edge.
            state     <= STALL;
            req_ready <= 1'b0;
            if (accept) begin
              pend_valid <= 1'b1;
              pend_rdata <= rsp_data;
              pend_err   <= req_err;
            end
          end else begin
            resp_valid <= accept;
            resp_rdata <= accept ? rsp_data : '0;
            resp_err   <= accept && req_err;
          end
        end
        STALL: begin
          if (resp_ready) begin
            state      <= RUN;
            req_ready  <= 1'b1;
            resp_valid <= pend_valid;
            resp_rdata <= pend_rdata;
            resp_err   <= pend_err;
            pend_valid <= 1'b0;
            pend_rdata <= '0;
            pend_err   <= 1'b0;
          end
        end
        default: begin
          state      <= INIT;
          sweep_cnt  <= '0;
          req_ready  <= 1'b0;
          init_done  <= 1'b0;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          pend_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_sync.sv
// Directed self-checking bench for data_mem_sync: a default 32-bit/256-word
// instance and a 64-bit/16-word instance sharing one clock.
module tb_data_mem_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n;

  // Instance A: defaults
  logic        a_rst_n = 1'b1;
  logic        a_req_valid = 1'b0, a_req_ready, a_req_we = 1'b0;
  logic [31:0] a_req_addr = '0, a_req_wdata = '0;
  logic [3:0]  a_req_be = '0;
  logic        a_resp_valid, a_resp_ready = 1'b1, a_resp_err, a_init_done;
  logic [31:0] a_resp_rdata;

  data_mem_sync dut_a (
    .clk(clk), .rst_n(a_rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .init_done(a_init_done)
  );

  // Instance B: 64-bit words, 16 deep
  logic        b_rst_n = 1'b1;
  logic        b_req_valid = 1'b0, b_req_ready, b_req_we = 1'b0;
  logic [31:0] b_req_addr = '0;
  logic [63:0] b_req_wdata = '0;
  logic [7:0]  b_req_be = '0;
  logic        b_resp_valid, b_resp_ready = 1'b1, b_resp_err, b_init_done;
  logic [63:0] b_resp_rdata;

  data_mem_sync #(.DATA_W(64), .DEPTH(16), .ADDR_W(32)) dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .init_done(b_init_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One request on A, presented for one edge; response checked right after.
  task automatic a_do(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be,
                      input logic [31:0] exp_d, input logic exp_e);
    a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr;
    a_req_wdata = wd; a_req_be = be;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    chk({tag, ".valid"}, {63'd0, a_resp_valid}, 64'd1);
    chk({tag, ".rdata"}, {32'd0, a_resp_rdata}, {32'd0, exp_d});
    chk({tag, ".err"},   {63'd0, a_resp_err},   {63'd0, exp_e});
  endtask

  task automatic b_do(input string tag, input logic we, input logic [31:0] addr,
                      input logic [63:0] wd, input logic [7:0] be,
                      input logic [63:0] exp_d, input logic exp_e);
    b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr;
    b_req_wdata = wd; b_req_be = be;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    chk({tag, ".valid"}, {63'd0, b_resp_valid}, 64'd1);
    chk({tag, ".rdata"}, b_resp_rdata, exp_d);
    chk({tag, ".err"},   {63'd0, b_resp_err}, {63'd0, exp_e});
  endtask

  initial begin
    // Reset both instances asynchronously before any clock edge.
    #1 a_rst_n = 1'b0; b_rst_n = 1'b0;
    #1;
    chk("rst.req_ready",  {63'd0, a_req_ready},  64'd0);
    chk("rst.resp_valid", {63'd0, a_resp_valid}, 64'd0);
    chk("rst.resp_rdata", {32'd0, a_resp_rdata}, 64'd0);
    chk("rst.resp_err",   {63'd0, a_resp_err},   64'd0);
    chk("rst.init_done",  {63'd0, a_init_done},  64'd0);

    // Hold a request during INIT; it must not be accepted until RUN.
    repeat (2) @(posedge clk);
    #1 a_rst_n = 1'b1;
    n = 0;
    while (!a_req_ready && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    chk("sweep.cycles", 64'(n), 64'd256);
    chk("sweep.init_done", {63'd0, a_init_done}, 64'd1);
    chk("idle.resp_valid", {63'd0, a_resp_valid}, 64'd0);

    // Last word reads as cleared.
    a_do("rd3fc", 1'b0, 32'h3FC, 32'h0, 4'h0, 32'h0, 1'b0);
    // Back-to-back partial write then read.
    a_do("wr10a", 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
    a_do("wr10b", 1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 1'b0);
    a_do("rd10",  1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);
    // Byte enables all zero: no change, no error.
    a_do("wrbe0", 1'b1, 32'h10, 32'h12345678, 4'b0000, 32'h0, 1'b0);
    a_do("rd10c", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);
    // Error cases: misaligned write, out-of-range read and write.
    a_do("wr11",  1'b1, 32'h11, 32'h55555555, 4'b1111, 32'h0, 1'b1);
    a_do("rd400", 1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1);
    a_do("wr400", 1'b1, 32'h400, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1);
    a_do("rd13",  1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1);
    a_do("rd10d", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);
    a_do("rd0",   1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    // Response consumed with no new request: resp_valid drops.
    @(posedge clk); #1;
    chk("drain.resp_valid", {63'd0, a_resp_valid}, 64'd0);

    // Stall: response held while resp_ready is low.
    a_resp_ready = 1'b0;
    a_do("stl", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("stl.hold.valid", {63'd0, a_resp_valid}, 64'd1);
      chk("stl.hold.rdata", {32'd0, a_resp_rdata}, 64'hDEADBEAA);
      chk("stl.hold.err",   {63'd0, a_resp_err},   64'd0);
      chk("stl.req_ready",  {63'd0, a_req_ready},  64'd0);
    end
    a_resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stl.release.valid", {63'd0, a_resp_valid}, 64'd0);
    chk("stl.release.ready", {63'd0, a_req_ready},  64'd1);

    // Reset during a stall: outputs clear at once, sweep reruns.
    a_resp_ready = 1'b0;
    a_do("stl2", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);
    @(posedge clk); #1;
    a_rst_n = 1'b0;
    #1;
    chk("mrst.resp_valid", {63'd0, a_resp_valid}, 64'd0);
    chk("mrst.resp_rdata", {32'd0, a_resp_rdata}, 64'd0);
    chk("mrst.req_ready",  {63'd0, a_req_ready},  64'd0);
    chk("mrst.init_done",  {63'd0, a_init_done},  64'd0);
    a_resp_ready = 1'b1;
    @(posedge clk); #1;
    a_rst_n = 1'b1;
    n = 0;
    while (!a_req_ready && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    chk("mrst.sweep.cycles", 64'(n), 64'd256);
    a_do("mrst.rd10", 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0);

    // Instance B: 64-bit words, 16 deep.
    b_rst_n = 1'b1;
    n = 0;
    while (!b_req_ready && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    chk("b.sweep.cycles", 64'(n), 64'd16);
    chk("b.init_done", {63'd0, b_init_done}, 64'd1);
    b_do("b.rd78",  1'b0, 32'h78, 64'h0, 8'h00, 64'h0, 1'b0);
    b_do("b.wr10a", 1'b1, 32'h10, 64'h01234567_DEADBEEF, 8'hFF, 64'h0, 1'b0);
    b_do("b.wr10b", 1'b1, 32'h10, 64'h00000000_000000AA, 8'h01, 64'h0, 1'b0);
    b_do("b.rd10",  1'b0, 32'h10, 64'h0, 8'h00, 64'h01234567_DEADBEAA, 1'b0);
    b_do("b.rd80",  1'b0, 32'h80, 64'h0, 8'h00, 64'h0, 1'b1);
    b_do("b.rd14",  1'b0, 32'h14, 64'h0, 8'h00, 64'h0, 1'b1);
    b_do("b.rd0",   1'b0, 32'h0,  64'h0, 8'h00, 64'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_sync.md
DATA_MEM_SYNC -- requirements
Module: data_mem_sync

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits; multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 256, word count; power of 2, >= 2.
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready at a clk edge.
REQ-008 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-010 SHALL have port req_wdata  input  DATA_W  write data.
REQ-011 SHALL have port req_be  input  DATA_W/8  byte enables; bit i covers req_wdata[8i+7:8i].
REQ-012 SHALL have port resp_valid  output  1  response present.
REQ-013 SHALL have port resp_ready  input  1  response consumed when resp_valid && resp_ready at a clk edge.
REQ-014 SHALL have port resp_rdata  output  DATA_W  read data; 0 for writes and errors.
REQ-015 SHALL have port resp_err  output  1  request misaligned or out of range.
REQ-016 SHALL have port init_done  output  1  memory clear sweep complete.

Function
REQ-017 SHALL use an FSM with states INIT, RUN, STALL; INIT is entered on reset.
REQ-018 INIT SHALL write zero to one word per cycle, index 0 up to DEPTH-1, then go to RUN and set init_done=1; the sweep takes exactly DEPTH cycles.
REQ-019 req_ready SHALL be 0 in INIT and STALL, and 1 in RUN.
REQ-020 With OFF = log2(DATA_W/8) and IW = log2(DEPTH), the word index SHALL be req_addr[OFF+IW-1:OFF].
REQ-021 A request SHALL be an error if req_addr[OFF-1:0] != 0 (misaligned) or req_addr[ADDR_W-1:OFF+IW] != 0 (out of range).
REQ-022 An accepted non-error write SHALL update only the enabled bytes at the accepting edge; req_be == 0 SHALL leave memory unchanged and is not an error.
REQ-023 An error request SHALL not modify memory.
REQ-024 Every accepted request SHALL produce exactly one response, with resp_valid=1 on the cycle after acceptance, in request order.
REQ-025 A read response SHALL return the word as updated by every write accepted earlier, including a write in the immediately preceding cycle.
REQ-026 In RUN, back-to-back requests SHALL be accepted one per cycle while resp_ready=1.
REQ-027 If resp_valid && !resp_ready, the FSM SHALL enter STALL and hold resp_valid, resp_rdata and resp_err stable until resp_ready=1, then return to RUN on that edge.
REQ-028 Memory content SHALL not change in STALL.
REQ-029 Requests SHALL be ignored in INIT; req_valid in INIT is held by the requester until accepted.

Reset
REQ-030 On rst_n=0, asynchronously: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, init_done=0, sweep counter=0, state=INIT.
REQ-031 Reset mid-operation SHALL drop any pending or stalled response and restart the full clear sweep.
REQ-032 The sweep SHALL start on the first clk edge after rst_n rises.

Verification
REQ-033 Release reset -> req_ready=0 for 256 cycles, then init_done=1; a read of addr 0x3FC returns 0x00000000 with resp_err=0.
REQ-034 Write 0xDEADBEEF to 0x10 with be=4'b1111, then write 0x000000AA to 0x10 with be=4'b0001 in the next cycle, then read 0x10 -> 0xDEADBEAA on the cycle after the read is accepted.
REQ-035 Write to 0x11 and read 0x400 -> each gives resp_err=1 and resp_rdata=0; memory at 0x10 and 0x0 is unchanged.
REQ-036 Hold resp_ready=0 for 3 cycles after a read of 0x10 -> resp_valid stays 1, the data stays 0xDEADBEAA, req_ready=0; the response clears one edge after resp_ready=1.
REQ-037 Assert rst_n=0 during a stall -> outputs go to 0 immediately; after release the sweep reruns and 0x10 reads 0.
REQ-038 Repeat REQ-033 and REQ-034 with DATA_W=64, DEPTH=16 -> 16-cycle sweep, OFF=3, out-of-range starts at 0x80.
